// File: rtl/rf_serial_frontend.sv
// rf_serial_frontend: bit-serial command frontend for a register file; define RF_SERIAL_PARITY_EN to add an even-parity bit and a sticky frame_err
module rf_serial_frontend #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sin,
  input  logic              sin_en,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_we,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [DATA_W-1:0] cmd_wdata,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rsp_data,
  output logic              rsp_ready,
  output logic              sout,
  output logic              sout_valid,
  output logic              busy
`ifdef RF_SERIAL_PARITY_EN
  ,
  output logic              frame_err
`endif
);
  localparam int MW = DATA_W > ADDR_W ? DATA_W : ADDR_W;
  localparam int CW = $clog2(MW + 1);
  typedef enum logic [2:0] {IDLE, OP, ADDR, DATA, PAR, ISSUE, WAIT_RSP, SEND} state_t;
`ifdef RF_SERIAL_PARITY_EN
  localparam state_t TAIL = PAR;
  logic par;
`else
  localparam state_t TAIL = ISSUE;
`endif
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] out_sr;
  logic last_addr, last_data, last_send;
  assign last_addr  = cnt == CW'(ADDR_W - 1);
  assign last_data  = cnt == CW'(DATA_W - 1);
  assign last_send  = last_data;
  assign cmd_valid  = state == ISSUE;
  assign rsp_ready  = state == WAIT_RSP;
  assign sout_valid = state == SEND;
  assign sout       = sout_valid & out_sr[DATA_W-1];
  assign busy       = !(state == IDLE || state == ADDR || state == DATA || state == PAR);
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // next-state decode; only ISSUE and WAIT_RSP advance without a strobe
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     if (sin_en && sin) nxt = OP;
      OP:       if (sin_en) nxt = ADDR;
      ADDR:     if (sin_en && last_addr) nxt = cmd_we ? DATA : TAIL;
      DATA:     if (sin_en && last_data) nxt = TAIL;
`ifdef RF_SERIAL_PARITY_EN
      PAR:      if (sin_en) nxt = (par ^ sin) ? IDLE : ISSUE;
`endif
      ISSUE:    if (cmd_ready) nxt = cmd_we ? IDLE : WAIT_RSP;
      WAIT_RSP: if (rsp_valid) nxt = SEND;
      SEND:     if (sin_en && last_send) nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end
  // field counter, command shifters, response shifter and frame parity
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt       <= '0;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      out_sr    <= '0;
`ifdef RF_SERIAL_PARITY_EN
      par       <= 1'b0;
      frame_err <= 1'b0;
`endif
    end else begin
      if (state != nxt) cnt <= '0;
      else if (sin_en && (state == ADDR || state == DATA || state == SEND)) cnt <= cnt + CW'(1);
      if (state == IDLE && sin_en && sin) begin
        cmd_we    <= 1'b0;
        cmd_addr  <= '0;
        cmd_wdata <= '0;
      end
      if (state == OP && sin_en) cmd_we <= sin;
      if (state == ADDR && sin_en) cmd_addr <= (cmd_addr << 1) | ADDR_W'(sin);
      if (state == DATA && sin_en) cmd_wdata <= (cmd_wdata << 1) | DATA_W'(sin);
      if (state == WAIT_RSP && rsp_valid) out_sr <= rsp_data;
      else if (state == SEND && sin_en) out_sr <= out_sr << 1;
`ifdef RF_SERIAL_PARITY_EN
      if (state == IDLE && sin_en && sin) par <= 1'b1;
      else if (sin_en && (state == OP || state == ADDR || state == DATA)) par <= par ^ sin;
      if (state == PAR && sin_en && (par ^ sin)) frame_err <= 1'b1;
`endif
    end
endmodule

// File: tb/tb_rf_serial_frontend.sv
// tb_rf_serial_frontend: table-driven frames with command/response scoreboards plus reset and parity sequences
module tb_rf_serial_frontend;
  localparam int DW = 64;
  localparam int AW = 5;
  logic clk = 0, rst_n = 0, sin = 0, sin_en = 0, cmd_ready = 0, rsp_valid = 0;
  logic [DW-1:0] rsp_data = '0;
  logic cmd_valid, cmd_we, rsp_ready, sout, sout_valid, busy;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
`ifdef RF_SERIAL_PARITY_EN
  logic frame_err;
`endif
  rf_serial_frontend #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sin_en(sin_en),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .sout(sout), .sout_valid(sout_valid), .busy(busy)
`ifdef RF_SERIAL_PARITY_EN
    , .frame_err(frame_err)
`endif
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  typedef struct {logic we; logic [AW-1:0] addr; logic [DW-1:0] data;} cmd_t;
  typedef struct {logic we; logic [AW-1:0] addr; logic [DW-1:0] data; int rdy; int rsp;} vec_t;
  cmd_t cmd_q[$];
  logic [DW-1:0] rsp_q[$];
  vec_t tv[7];

  task automatic chk(string name, logic [DW-1:0] got, logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // one strobed bit followed by an idle cycle carrying the inverted bit, which must be ignored
  task automatic strobe(logic b);
    sin = b; sin_en = 1;
    @(negedge clk);
    sin_en = 0; sin = ~b;
    @(negedge clk);
  endtask

  task automatic send_frame(logic we, logic [AW-1:0] a, logic [DW-1:0] d, logic bad);
    logic bits[$];
    logic p;
    cmd_t e;
    bits = {1'b1, we};
    for (int i = AW - 1; i >= 0; i--) bits.push_back(a[i]);
    if (we) for (int i = DW - 1; i >= 0; i--) bits.push_back(d[i]);
    p = 0;
    foreach (bits[i]) p ^= bits[i];
`ifdef RF_SERIAL_PARITY_EN
    bits.push_back(p ^ bad);
`endif
    if (!bad) begin
      e.we = we; e.addr = a; e.data = we ? d : '0;
      cmd_q.push_back(e);
    end
    foreach (bits[i]) begin
      if (i == bits.size() - 1) chk("valid_before_last_bit", cmd_valid, 0);
      strobe(bits[i]);
    end
  endtask

  task automatic do_cmd(int rdy);
    int n;
    cmd_t e;
    n = 0;
    while (!cmd_valid && n < 40) begin @(negedge clk); n++; end
    chk("cmd_valid_timeout", cmd_valid, 1);
    chk("cmd_q_nonempty", cmd_q.size() > 0, 1);
    if (!cmd_valid || cmd_q.size() == 0) return;
    e = cmd_q.pop_front();
    chk("busy_issue", busy, 1);
    for (int k = 0; k < rdy; k++) begin
      chk("hold_valid", cmd_valid, 1);
      chk("hold_we", cmd_we, e.we);
      chk("hold_addr", cmd_addr, e.addr);
      chk("hold_wdata", cmd_wdata, e.data);
      @(negedge clk);
    end
    cmd_ready = 1;
    chk("cmd_we", cmd_we, e.we);
    chk("cmd_addr", cmd_addr, e.addr);
    chk("cmd_wdata", cmd_wdata, e.data);
    @(negedge clk);
    cmd_ready = 0;
    chk("valid_single_cycle", cmd_valid, 0);
  endtask

  task automatic do_rsp(int dly, logic [DW-1:0] d);
    int n;
    logic ok;
    logic [DW-1:0] got, exp;
    n = 0;
    while (!rsp_ready && n < 20) begin @(negedge clk); n++; end
    chk("rsp_ready_timeout", rsp_ready, 1);
    chk("busy_wait", busy, 1);
    repeat (dly) @(negedge clk);
    chk("rsp_ready_held", rsp_ready, 1);
    rsp_data = d; rsp_valid = 1; rsp_q.push_back(d);
    @(negedge clk);
    rsp_valid = 0; rsp_data = '0;
    chk("rsp_ready_drop", rsp_ready, 0);
    ok = 1; got = '0;
    exp = rsp_q.pop_front();
    for (int i = 0; i < DW; i++) begin
      ok &= sout_valid;
      got = {got[DW-2:0], sout};
      sin = 1; sin_en = 1;
      @(negedge clk);
      sin_en = 0;
      if (i % 3 == 0) @(negedge clk);
    end
    sin = 0;
    chk("sout_valid_run", ok, 1);
    chk("sout_data", got, exp);
    chk("sout_valid_end", sout_valid, 0);
    chk("busy_after_send", busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks %0d", checks);
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] w;
    tv[0] = '{1, 5'd3, 64'hDEADBEEF_01234567, 0, 0};
    tv[1] = '{1, 5'd3, 64'hDEADBEEF_01234567, 10, 0};
    tv[2] = '{0, 5'd31, 64'h8000_0000_0000_0001, 0, 5};
    tv[3] = '{1, 5'd0, 64'h0, 2, 0};
    tv[4] = '{0, 5'd0, 64'hA5A5_5A5A_0FF0_F00F, 3, 0};
    tv[5] = '{1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0};
    tv[6] = '{0, 5'd17, 64'h0123_4567_89AB_CDEF, 0, 2};
    repeat (2) @(negedge clk);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_cmd_we", cmd_we, 0);
    chk("rst_cmd_addr", cmd_addr, 0);
    chk("rst_cmd_wdata", cmd_wdata, 0);
    chk("rst_rsp_ready", rsp_ready, 0);
    chk("rst_sout", sout, 0);
    chk("rst_sout_valid", sout_valid, 0);
    chk("rst_busy", busy, 0);
`ifdef RF_SERIAL_PARITY_EN
    chk("rst_frame_err", frame_err, 0);
`endif
    rst_n = 1;
    strobe(0);
    chk("idle_ignores_zero", busy, 0);
    for (int t = 0; t < 7; t++) begin
      send_frame(tv[t].we, tv[t].addr, tv[t].data, 0);
      do_cmd(tv[t].rdy);
      if (!tv[t].we) do_rsp(tv[t].rsp, tv[t].data);
    end
    w = 64'hDEADBEEF_01234567;
    strobe(1); strobe(1);
    for (int i = AW - 1; i >= 0; i--) strobe(3 >> i & 1);
    for (int i = DW - 1; i >= DW - 20; i--) strobe(w[i]);
    #2 rst_n = 0;
    #1 chk("async_rst_wdata", cmd_wdata, 0);
    chk("async_rst_we", cmd_we, 0);
    @(negedge clk);
    rst_n = 1;
    send_frame(0, 5'd7, '0, 0);
    do_cmd(0);
    do_rsp(1, 64'hC0FF_EE00_1234_5678);
    send_frame(0, 5'd9, '0, 0);
    do_cmd(0);
    @(negedge clk);
    chk("pre_rst_rsp_ready", rsp_ready, 1);
    #2 rst_n = 0;
    #1 chk("rst_mid_rsp_ready", rsp_ready, 0);
    chk("rst_mid_busy", busy, 0);
    @(negedge clk);
    rst_n = 1;
`ifdef RF_SERIAL_PARITY_EN
    begin
      int seen;
      send_frame(1, 5'd5, 64'h1357_9BDF_2468_ACE0, 1);
      seen = 0;
      repeat (30) begin @(negedge clk); seen += int'(cmd_valid); end
      chk("bad_par_no_cmd", seen, 0);
      chk("bad_par_frame_err", frame_err, 1);
      send_frame(1, 5'd5, 64'h1357_9BDF_2468_ACE0, 0);
      do_cmd(0);
      chk("frame_err_sticky", frame_err, 1);
    end
`endif
    chk("cmd_q_drained", cmd_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rf_serial_frontend.md
RF_SERIAL_FRONTEND -- requirements
Module: rf_serial_frontend

Interface
REQ-001 SHALL have parameter DATA_W, default 64: register data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5: register address width in bits.
REQ-003 SHALL have port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port sin, input, 1: serial command bit, sampled only when sin_en=1.
REQ-006 SHALL have port sin_en, input, 1: bit strobe that qualifies sin and sout advance.
REQ-007 SHALL have port cmd_valid, output, 1: a command is presented to the register-file stage.
REQ-008 SHALL have port cmd_ready, input, 1: the register-file stage accepts the command.
REQ-009 SHALL have port cmd_we, output, 1: 1=write, 0=read.
REQ-010 SHALL have port cmd_addr, output, ADDR_W: target register.
REQ-011 SHALL have port cmd_wdata, output, DATA_W: write data; 0 for reads.
REQ-012 SHALL have port rsp_valid, input, 1: read data is available from the register file.
REQ-013 SHALL have port rsp_data, input, DATA_W: read data.
REQ-014 SHALL have port rsp_ready, output, 1: frontend accepts rsp_data.
REQ-015 SHALL have port sout, output, 1: serial read-data bit.
REQ-016 SHALL have port sout_valid, output, 1: sout holds a valid read-data bit.
REQ-017 SHALL have port busy, output, 1: high in any state other than IDLE, ADDR, DATA, or PAR.
REQ-018 SHALL have port frame_err, output, 1: sticky parity error flag; exists only with RF_SERIAL_PARITY_EN.

Function
REQ-019 SHALL implement FSM states IDLE, OP, ADDR, DATA, PAR, ISSUE, WAIT_RSP, SEND.
REQ-020 IDLE: a strobed sin=1 is the start bit and SHALL move the FSM to OP; a strobed sin=0 SHALL be ignored.
REQ-021 OP: the strobed bit SHALL be latched as cmd_we, and the FSM SHALL move to ADDR.
REQ-022 ADDR: SHALL shift in ADDR_W strobed bits MSB first, then move to DATA if cmd_we=1, else to PAR/ISSUE.
REQ-023 DATA: SHALL shift in DATA_W strobed bits MSB first, then move to PAR/ISSUE.
REQ-024 Without RF_SERIAL_PARITY_EN the FSM SHALL skip PAR and go straight to ISSUE.
REQ-025 Clock cycles with sin_en=0 SHALL leave all shift registers, bit counters and the FSM state unchanged, except in ISSUE and WAIT_RSP.
REQ-026 ISSUE: cmd_valid SHALL be 1, with cmd_we/cmd_addr/cmd_wdata stable until the cycle where cmd_valid&&cmd_ready is seen.
REQ-027 On the ISSUE handshake, a write SHALL return the FSM to IDLE and a read SHALL move it to WAIT_RSP.
REQ-028 cmd_valid SHALL rise no earlier than the clock after the last frame bit is sampled.
REQ-029 cmd_valid SHALL NOT be withdrawn before the handshake.
REQ-030 WAIT_RSP: rsp_ready SHALL be 1, and rsp_valid&&rsp_ready SHALL capture rsp_data into the output shifter and move the FSM to SEND.
REQ-031 rsp_ready SHALL be 0 in every other state.
REQ-032 SEND: sout SHALL equal the shifter MSB, and sout_valid SHALL be 1.
REQ-033 SEND: each strobe SHALL advance the shifter one bit, and after DATA_W strobes the FSM SHALL return to IDLE with sout_valid=0.
REQ-034 sin values strobed during ISSUE, WAIT_RSP or SEND SHALL be discarded and SHALL NOT start a frame.
REQ-035 Bit counters SHALL be sized to count DATA_W without wrap-around; counters SHALL reset to 0 on entering each field.

Reset
REQ-036 rst_n=0 SHALL asynchronously force IDLE at any point, including mid-frame and mid-handshake, discarding any partial frame or response.
REQ-037 During reset: cmd_valid=0, cmd_we=0, cmd_addr=0, cmd_wdata=0, rsp_ready=0, sout=0, sout_valid=0, busy=0, frame_err=0, all shifters and counters 0.

Configuration
REQ-038 With RF_SERIAL_PARITY_EN defined, PAR SHALL sample one strobed bit making the frame (start+op+addr+data+parity) even parity.
REQ-039 On a parity match the FSM SHALL go to ISSUE; on a mismatch it SHALL set frame_err, discard the frame, and go to IDLE with no cmd_valid pulse.
REQ-040 frame_err SHALL clear only on reset.
REQ-041 Without RF_SERIAL_PARITY_EN, the frame SHALL have no parity bit and the frame_err port SHALL be absent.

Verification
REQ-042 Write 0xDEADBEEF_01234567 to addr 3, with cmd_ready=1 -> exactly one cmd_valid cycle with we=1, addr=3, wdata=0xDEADBEEF_01234567, then IDLE.
REQ-043 Same write with cmd_ready held 0 for 10 cycles -> cmd_valid and the cmd fields stay stable for all 10 cycles; handshake on cycle 11.
REQ-044 Read addr 31, answered with rsp_valid carrying 0x8000_0000_0000_0001 after 5 cycles -> sout is 1, then 62 zeros, then 1 over 64 strobes; then IDLE.
REQ-045 rst_n pulsed low after 20 DATA bits, then a valid read frame to addr 7 -> only the addr-7 read is issued.
REQ-046 (PARITY_EN) Write frame with a flipped parity bit -> no cmd_valid and frame_err=1; a following good frame is issued while frame_err stays 1.
REQ-047 Strobed sin=1 bits during SEND -> ignored, sout sequence unaffected.
